// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: BCD width and
// active-low segment patterns ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Counter width for a given modulus; a modulus of 1 still gets one bit.
  function automatic int cnt_w(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the digit counter chain (master) and the scan driver (slave):
// digit values and display controls in, board pin levels out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic [BCD_W*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]       dp_mask;
  logic                        blank_lz;
  logic [NUM_DIGITS-1:0]       blink_mask;
  logic [6:0]                  seg;
  logic                        dp;
  logic [NUM_DIGITS-1:0]       an;

  modport master (
    output digits, dp_mask, blank_lz, blink_mask,
    input  seg, dp, an
  );

  modport slave (
    input  digits, dp_mask, blank_lz, blink_mask,
    output seg, dp, an
  );

endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 and
// an asserted blank both give a dark digit.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display scanner: one dark cycle per digit
// slot, leading-zero blanking, per-digit decimal points and blinking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int CW = cnt_w(REFRESH_DIV);
  localparam int IW = cnt_w(NUM_DIGITS);
  localparam int FW = cnt_w(BLINK_FRAMES);

  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         fcnt;
  logic                  blink_phase;
  logic                  cnt_wrap, idx_wrap, fcnt_wrap;

  logic [BCD_W-1:0]      digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS-1:0] suppress;
  logic                  run_zero;

  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi]  = bus.digits[gi*BCD_W +: BCD_W];
      assign digit_zero[gi] = (digit_arr[gi] == '0);
    end
  endgenerate

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    run_zero = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero    = run_zero & digit_zero[i];
      suppress[i] = (i != 0) && bus.blank_lz && run_zero;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd   (digit_arr[idx]),
    .blank (suppress[idx]),
    .seg   (dec_seg)
  );

  assign cnt_wrap  = (cnt == CNT_MAX);
  assign idx_wrap  = (idx == IDX_MAX);
  assign fcnt_wrap = (fcnt == FCNT_MAX);

  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if ((cnt != '0) && !(blink_phase && bus.blink_mask[idx])) begin
      an_next  = ~(NUM_DIGITS'(1) << idx);
      seg_next = dec_seg;
      dp_next  = ~bus.dp_mask[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      an_reg      <= '1;
      seg_reg     <= SEG_BLANK;
      dp_reg      <= 1'b1;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) begin
        idx <= idx_wrap ? '0 : idx + IW'(1);
        if (idx_wrap) begin
          fcnt <= fcnt_wrap ? '0 : fcnt + FW'(1);
          if (fcnt_wrap) begin
            blink_phase <= ~blink_phase;
          end
        end
      end
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign bus.an  = an_reg;
  assign bus.seg = seg_reg;
  assign bus.dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with 4 digits, 4-cycle slots and
// 2-frame blink half-periods; expectations are keyed by edge since reset release.
module tb_seg7_scan_driver;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         chk_seg;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   timeout_flag = 1'b0;
  bit   timeout_seen = 1'b0;
  exp_t sb[$];

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: every negedge checks the anode invariant and retires due entries.
  always @(negedge clk) begin
    exp_t e;
    n_checks++;
    if ($countones(~bus.an) > 1) begin
      n_fail++;
      $display("FAIL one_hot_an edge %0d: an=%b, required at most one low bit", cyc, bus.an);
    end
    if (timeout_flag && !timeout_seen) begin
      timeout_seen = 1'b1;
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, required 0", sb.size());
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s missed: due edge %0d, now edge %0d", e.name, e.cyc, cyc);
      end else if (bus.an !== e.an || (e.chk_seg && bus.seg !== e.seg) || bus.dp !== e.dp) begin
        n_fail++;
        $display("FAIL %s edge %0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                 e.name, cyc, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
      end else begin
        $display("ok   %s edge %0d: an=%b seg=%b dp=%b", e.name, cyc, bus.an, bus.seg, bus.dp);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input bit cs, input string nm);
    exp_t e;
    e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.chk_seg = cs; e.name = nm;
    sb.push_back(e);
  endtask

  // One slot: dark on the first edge, then three lit edges.
  task automatic push_slot(input int base, input logic [3:0] a, input logic [6:0] s,
                           input logic d, input bit cs, input string nm);
    push(base, 4'b1111, 7'h7F, 1'b1, 1'b1, {nm, "_dead"});
    for (int k = 1; k < 4; k++) push(base + k, a, s, d, cs, nm);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      timeout_flag = 1'b1;
      @(negedge clk);
      sb.delete();
    end
  endtask

  task automatic restart(input logic [15:0] d, input logic [3:0] dpm,
                         input logic blz, input logic [3:0] blk);
    wait_empty();
    @(posedge clk);
    #2 reset = 1'b1;
    bus.digits = d; bus.dp_mask = dpm; bus.blank_lz = blz; bus.blink_mask = blk;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.digits = 16'h1234; bus.dp_mask = 4'b0000; bus.blank_lz = 1'b0; bus.blink_mask = 4'b0000;
    push(0, 4'b1111, 7'h7F, 1'b1, 1'b1, "reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_slot(1,  4'b1110, 7'b0011001, 1'b1, 1'b1, "scan_d0");
    push_slot(5,  4'b1101, 7'b0110000, 1'b1, 1'b1, "scan_d1");
    push_slot(9,  4'b1011, 7'b0100100, 1'b1, 1'b1, "scan_d2");
    push_slot(13, 4'b0111, 7'b1111001, 1'b1, 1'b1, "scan_d3");
    push_slot(17, 4'b1110, 7'b0011001, 1'b1, 1'b1, "scan_d0_again");

    restart(16'h0040, 4'b0000, 1'b1, 4'b0000);
    push_slot(1,  4'b1110, 7'b1000000, 1'b1, 1'b1, "lz_d0");
    push_slot(5,  4'b1101, 7'b0011001, 1'b1, 1'b1, "lz_d1");
    push_slot(9,  4'b1011, 7'b1111111, 1'b1, 1'b1, "lz_d2");
    push_slot(13, 4'b0111, 7'b1111111, 1'b1, 1'b1, "lz_d3");

    restart(16'h0040, 4'b0000, 1'b0, 4'b0000);
    push_slot(1,  4'b1110, 7'b1000000, 1'b1, 1'b1, "nolz_d0");
    push_slot(5,  4'b1101, 7'b0011001, 1'b1, 1'b1, "nolz_d1");
    push_slot(9,  4'b1011, 7'b1000000, 1'b1, 1'b1, "nolz_d2");
    push_slot(13, 4'b0111, 7'b1000000, 1'b1, 1'b1, "nolz_d3");

    restart(16'hF000, 4'b0100, 1'b0, 4'b0000);
    push_slot(1,  4'b1110, 7'b1000000, 1'b1, 1'b1, "dp_d0");
    push_slot(5,  4'b1101, 7'b1000000, 1'b1, 1'b1, "dp_d1");
    push_slot(9,  4'b1011, 7'b1000000, 1'b0, 1'b1, "dp_d2");
    push_slot(13, 4'b0111, 7'b1111111, 1'b1, 1'b1, "bad_bcd_d3");

    // Blink on digit 0 with its decimal point lit: dark in frames 2 and 3.
    restart(16'h1234, 4'b0001, 1'b0, 4'b0001);
    for (int f = 0; f < 5; f++) begin
      if (f == 2 || f == 3) push_slot(f*16 + 1, 4'b1111, 7'h7F, 1'b1, 1'b0, "blink_d0_off");
      else                  push_slot(f*16 + 1, 4'b1110, 7'b0011001, 1'b0, 1'b1, "blink_d0_on");
      push_slot(f*16 + 5,  4'b1101, 7'b0110000, 1'b1, 1'b1, "blink_d1");
      push_slot(f*16 + 9,  4'b1011, 7'b0100100, 1'b1, 1'b1, "blink_d2");
      push_slot(f*16 + 13, 4'b0111, 7'b1111001, 1'b1, 1'b1, "blink_d3");
    end

    // Reset during lit cycle 2 of digit 2 while blink_phase is 1.
    restart(16'h1234, 4'b0001, 1'b0, 4'b0001);
    push_slot(33, 4'b1111, 7'h7F, 1'b1, 1'b0, "rst_pre_d0_off");
    push_slot(37, 4'b1101, 7'b0110000, 1'b1, 1'b1, "rst_pre_d1");
    push(41, 4'b1111, 7'h7F, 1'b1, 1'b1, "rst_pre_d2_dead");
    push(42, 4'b1011, 7'b0100100, 1'b1, 1'b1, "rst_pre_d2");
    push(43, 4'b1111, 7'h7F, 1'b1, 1'b1, "rst_async_off");
    repeat (43) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_slot(1, 4'b1110, 7'b0011001, 1'b0, 1'b1, "rst_post_d0");
    push_slot(5, 4'b1101, 7'b0110000, 1'b1, 1'b1, "rst_post_d1");
    wait_empty();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
